// File: rtl/fetcher_icache_if.sv
// Program-memory read bus between the fetcher (master) and program memory (slave).
interface fetcher_icache_if #(
   parameter int ADDR_BITS = 8,
   parameter int DATA_BITS = 16
) ();
   logic                 mem_read_valid;
   logic [ADDR_BITS-1:0] mem_read_address;
   logic                 mem_read_ready;
   logic [DATA_BITS-1:0] mem_read_data;

   modport master (
      output mem_read_valid,
      output mem_read_address,
      input  mem_read_ready,
      input  mem_read_data
   );

   modport slave (
      input  mem_read_valid,
      input  mem_read_address,
      output mem_read_ready,
      output mem_read_data
   );
endinterface

// File: rtl/fetcher_icache.sv
// Instruction fetcher with a direct-mapped, one-instruction-per-line cache in front of program memory.
//
// state    | meaning
// IDLE     | waiting for core_state==FETCH, performs one cache lookup
// FETCHING | miss outstanding on the memory bus, waiting for mem_read_ready
// FETCHED  | instruction held until core_state==DECODE
module fetcher_icache #(
   parameter int PROGRAM_MEM_ADDR_BITS = 8,
   parameter int PROGRAM_MEM_DATA_BITS = 16,
   parameter int CACHE_LINES           = 16
) (
   input  logic                             clk,
   input  logic                             reset,
   input  logic [2:0]                       core_state,
   input  logic [PROGRAM_MEM_ADDR_BITS-1:0] current_pc,
   input  logic                             cache_flush,
   fetcher_icache_if.master                 mem,
   output logic [2:0]                       fetcher_state,
   output logic [PROGRAM_MEM_DATA_BITS-1:0] instruction,
   output logic [31:0]                      cache_hit_count,
   output logic [31:0]                      cache_miss_count,
   output logic [31:0]                      cache_total_requests,
   output logic [31:0]                      cache_memory_wait_cycles
);
   localparam int AW       = PROGRAM_MEM_ADDR_BITS;
   localparam int DW       = PROGRAM_MEM_DATA_BITS;
   localparam int IDX_BITS = $clog2(CACHE_LINES);
   localparam int TAG_BITS = AW - IDX_BITS;

   localparam logic [2:0] CORE_FETCH  = 3'b001;
   localparam logic [2:0] CORE_DECODE = 3'b010;

   typedef enum logic [2:0] {
      S_IDLE     = 3'b000,
      S_FETCHING = 3'b001,
      S_FETCHED  = 3'b010
   } state_e;

   state_e                 state_q, state_d;
   logic                   mem_valid_q, mem_valid_d;
   logic [AW-1:0]          mem_addr_q, mem_addr_d;
   logic [DW-1:0]          instr_q, instr_d;
   logic [31:0]            hit_q, hit_d;
   logic [31:0]            miss_q, miss_d;
   logic [31:0]            total_q, total_d;
   logic [31:0]            wait_q, wait_d;
   logic [CACHE_LINES-1:0] valid_q, valid_d;

   logic [TAG_BITS-1:0]    tag_q  [CACHE_LINES];
   logic [DW-1:0]          data_q [CACHE_LINES];

   logic [IDX_BITS-1:0]    lk_idx, fill_idx;
   logic [TAG_BITS-1:0]    lk_tag, fill_tag;
   logic                   lk_hit;
   logic                   fill_we;

   assign lk_idx   = current_pc[IDX_BITS-1:0];
   assign lk_tag   = current_pc[AW-1:IDX_BITS];
   assign lk_hit   = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
   // The fill targets the registered request address, not whatever PC the core shows now.
   assign fill_idx = mem_addr_q[IDX_BITS-1:0];
   assign fill_tag = mem_addr_q[AW-1:IDX_BITS];

   always_comb begin
      state_d     = state_q;
      mem_valid_d = mem_valid_q;
      mem_addr_d  = mem_addr_q;
      instr_d     = instr_q;
      hit_d       = hit_q;
      miss_d      = miss_q;
      total_d     = total_q;
      wait_d      = wait_q;
      fill_we     = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (core_state == CORE_FETCH) begin
               total_d = total_q + 32'd1;
               if (lk_hit) begin
                  instr_d = data_q[lk_idx];
                  hit_d   = hit_q + 32'd1;
                  state_d = S_FETCHED;
               end else begin
                  miss_d      = miss_q + 32'd1;
                  mem_valid_d = 1'b1;
                  mem_addr_d  = current_pc;
                  state_d     = S_FETCHING;
               end
            end
         end
         S_FETCHING: begin
            wait_d = wait_q + 32'd1;
            if (mem.mem_read_ready) begin
               instr_d     = mem.mem_read_data;
               mem_valid_d = 1'b0;
               fill_we     = 1'b1;
               state_d     = S_FETCHED;
            end
         end
         S_FETCHED: begin
            if (core_state == CORE_DECODE) begin
               state_d = S_IDLE;
            end
         end
         default: begin
            state_d     = S_IDLE;
            mem_valid_d = 1'b0;
         end
      endcase

      valid_d = valid_q;
      if (fill_we) begin
         valid_d[fill_idx] = 1'b1;
      end
      // Flush wins over a coincident fill; lookups this cycle already used valid_q.
      if (cache_flush) begin
         valid_d = '0;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= S_IDLE;
         mem_valid_q <= 1'b0;
         mem_addr_q  <= '0;
         instr_q     <= '0;
         hit_q       <= '0;
         miss_q      <= '0;
         total_q     <= '0;
         wait_q      <= '0;
         valid_q     <= '0;
      end else begin
         state_q     <= state_d;
         mem_valid_q <= mem_valid_d;
         mem_addr_q  <= mem_addr_d;
         instr_q     <= instr_d;
         hit_q       <= hit_d;
         miss_q      <= miss_d;
         total_q     <= total_d;
         wait_q      <= wait_d;
         valid_q     <= valid_d;
      end
   end

   // Tag/data storage is qualified by valid_q, so it needs no reset.
   always_ff @(posedge clk) begin
      if (fill_we) begin
         tag_q[fill_idx]  <= fill_tag;
         data_q[fill_idx] <= mem.mem_read_data;
      end
   end

   assign mem.mem_read_valid       = mem_valid_q;
   assign mem.mem_read_address     = mem_addr_q;
   assign fetcher_state            = state_q;
   assign instruction              = instr_q;
   assign cache_hit_count          = hit_q;
   assign cache_miss_count         = miss_q;
   assign cache_total_requests     = total_q;
   assign cache_memory_wait_cycles = wait_q;
endmodule

// File: doc/fetcher_icache.md
FETCHER_ICACHE -- requirements
Module: fetcher_icache

Interface
REQ-001 SHALL have parameter PROGRAM_MEM_ADDR_BITS, default 8, instruction address width.
REQ-002 SHALL have parameter PROGRAM_MEM_DATA_BITS, default 16, instruction width.
REQ-003 SHALL have parameter CACHE_LINES, default 16, power of two, one instruction per line, direct-mapped.
REQ-004 SHALL use one clock and an asynchronous active-low reset, with ports as follows.
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low.
- core_state  input  3  scheduler state: FETCH=001, DECODE=010.
- current_pc  input  ADDR_BITS  PC to fetch.
- cache_flush  input  1  invalidate all lines.
- mem_read_valid  output  1  program-memory read request.
- mem_read_address  output  ADDR_BITS  request address.
- mem_read_ready  input  1  read data valid this cycle.
- mem_read_data  input  DATA_BITS  returned instruction.
- fetcher_state  output  3  IDLE=000, FETCHING=001, FETCHED=010.
- instruction  output  DATA_BITS  fetched instruction.
- cache_hit_count  output  32  lookup hits.
- cache_miss_count  output  32  lookup misses.
- cache_total_requests  output  32  lookups performed.
- cache_memory_wait_cycles  output  32  cycles spent in FETCHING.

Function
REQ-005 Address split SHALL be: index = current_pc[log2(CACHE_LINES)-1:0]; tag = the remaining upper PC bits; each line holds a valid bit, a tag and an instruction.
REQ-006 In IDLE with core_state==FETCH, one lookup SHALL occur and cache_total_requests SHALL increment by 1.
REQ-007 On a hit (valid and tag match), the lookup SHALL register the line data into instruction and increment cache_hit_count, and the block SHALL enter FETCHED next cycle (1-cycle latency).
REQ-008 On a miss, the lookup SHALL set mem_read_valid=1 and mem_read_address=current_pc, increment cache_miss_count, and the block SHALL enter FETCHING.
REQ-009 In FETCHING, cache_memory_wait_cycles SHALL increment by 1 every cycle, including the cycle in which mem_read_ready is high.
REQ-010 In FETCHING with mem_read_ready=1, the block SHALL register mem_read_data into instruction, write it to the indexed line with valid=1 and the new tag, drop mem_read_valid next cycle, and enter FETCHED.
REQ-011 mem_read_valid and mem_read_address SHALL stay stable while in FETCHING until ready is sampled.
REQ-012 In FETCHED, instruction SHALL be held; the block SHALL go to IDLE when core_state==DECODE and otherwise stay in FETCHED.
REQ-013 mem_read_ready SHALL be ignored outside FETCHING.
REQ-014 core_state values other than FETCH in IDLE SHALL cause no lookup and no counter change.
REQ-015 cache_flush=1 SHALL clear all valid bits at that clock edge and SHALL NOT disturb an outstanding fill request.
REQ-016 When flush coincides with a fill, the flush SHALL win and the filled line SHALL be left invalid, while instruction is still updated and FETCHED is still entered.
REQ-017 When flush coincides with an IDLE lookup, the lookup SHALL use the pre-flush contents.
REQ-018 All counters SHALL be 32-bit and wrap modulo 2^32.
REQ-019 Invariant: cache_hit_count + cache_miss_count == cache_total_requests (mod 2^32).
REQ-020 fetcher_state encodings 011-111 SHALL be unreachable; if entered, the block SHALL recover to IDLE next cycle.

Reset
REQ-021 reset low SHALL immediately, asynchronously, set: fetcher_state=IDLE, mem_read_valid=0, mem_read_address=0, instruction=0, all four counters=0, all line valid bits=0.
REQ-022 Reset asserted mid-FETCHING SHALL abort the request with no line written, and a late mem_read_ready after release SHALL be ignored.
REQ-023 After reset deassertion the block SHALL accept a lookup on the first rising edge.

Verification
REQ-024 Cold miss: pc=0x05, memory returns 0x1234 after 3 wait cycles -> mem_read_valid=1 with address 0x05, instruction=0x1234, miss=1, total=1, wait=3, FETCHED.
REQ-025 Hit: refetch pc=0x05 after DECODE -> no mem_read_valid, FETCHED 1 cycle after FETCH, instruction=0x1234, hit=1, total=2.
REQ-026 Conflict: pc=0x15 after 0x05 (same index, tag 1 vs 0) -> miss; a subsequent 0x05 misses again; final miss=3, hit=0.
REQ-027 Flush: fill 0x05, pulse cache_flush, refetch 0x05 -> miss. Flush coincident with the ready cycle -> next lookup of that pc misses.
REQ-028 Reset mid-fetch: drive reset low during FETCHING -> mem_read_valid=0 and state=IDLE with no clock edge; counters=0; a ready pulse after release causes no state change.
REQ-029 Random 10k fetches -> the invariant holds, and every instruction equals the memory model's data at the fetched pc.
